// File: rtl/bg_rom_arbiter.sv
// Shares the single-port background ROM between display scan-out and game-logic lookups.
// Optional grant/wait statistics are enabled by defining BG_ARB_STATS_EN.
module bg_rom_arbiter #(
  parameter int ROM_W  = 320,
  parameter int ROM_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [9:0]        hcount,
  input  logic [8:0]        vcount,
  output logic [PIX_W-1:0]  disp_pixel,
  output logic              disp_valid,
  input  logic              gl_req,
  input  logic [8:0]        gl_x,
  input  logic [7:0]        gl_y,
  output logic              gl_ack,
  output logic              gl_rvalid,
  output logic [PIX_W-1:0]  gl_rdata,
  output logic              gl_oob,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [15:0]       stat_gl_grants,
  output logic [15:0]       stat_gl_wait_max
);

  typedef enum logic [1:0] {S_IDLE, S_DISP, S_GL} state_t;

  // state_reg/oob_reg form the first tag stage; tag_*_reg the second.
  state_t state_reg;
  logic   oob_reg;
  state_t tag_owner_reg;
  logic   tag_oob_reg;

  logic              grant_gl;
  logic              gl_out_of_range;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] gl_addr;

  assign grant_gl        = gl_req && !de;
  assign gl_out_of_range = (int'(gl_x) >= ROM_W) || (int'(gl_y) >= ROM_H);
  assign disp_addr       = ADDR_W'(vcount >> 1) * ADDR_W'(ROM_W) + ADDR_W'(hcount >> 1);
  assign gl_addr         = ADDR_W'(gl_y) * ADDR_W'(ROM_W) + ADDR_W'(gl_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      oob_reg       <= 1'b0;
      tag_owner_reg <= S_IDLE;
      tag_oob_reg   <= 1'b0;
      rom_addr      <= '0;
      gl_ack        <= 1'b0;
      disp_valid    <= 1'b0;
      disp_pixel    <= '0;
      gl_rvalid     <= 1'b0;
      gl_rdata      <= '0;
      gl_oob        <= 1'b0;
    end else begin
      gl_ack  <= 1'b0;
      oob_reg <= 1'b0;
      if (de) begin
        state_reg <= S_DISP;
        rom_addr  <= disp_addr;
      end else if (gl_req) begin
        state_reg <= S_GL;
        gl_ack    <= 1'b1;
        oob_reg   <= gl_out_of_range;
        // Out-of-range lookups skip the ROM entirely and leave the address alone.
        if (!gl_out_of_range) begin
          rom_addr <= gl_addr;
        end
      end else begin
        state_reg <= S_IDLE;
      end

      tag_owner_reg <= state_reg;
      tag_oob_reg   <= oob_reg;

      disp_valid <= (tag_owner_reg == S_DISP);
      gl_rvalid  <= (tag_owner_reg == S_GL);
      gl_oob     <= (tag_owner_reg == S_GL) && tag_oob_reg;
      if (tag_owner_reg == S_DISP) begin
        disp_pixel <= rom_data;
      end
      if (tag_owner_reg == S_GL) begin
        gl_rdata <= tag_oob_reg ? '0 : rom_data;
      end
    end
  end

`ifdef BG_ARB_STATS_EN
  logic [15:0] grants_reg;
  logic [15:0] wait_reg;
  logic [15:0] wait_max_reg;
  logic [15:0] wait_next;

  // Wait length is tracked per request: cleared on grant or withdrawal.
  always_comb begin
    wait_next = wait_reg;
    if (grant_gl || !gl_req) begin
      wait_next = '0;
    end else if (wait_reg != 16'hFFFF) begin
      wait_next = wait_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_reg   <= '0;
      wait_reg     <= '0;
      wait_max_reg <= '0;
    end else begin
      if (grant_gl && grants_reg != 16'hFFFF) begin
        grants_reg <= grants_reg + 16'd1;
      end
      wait_reg <= wait_next;
      if (wait_next > wait_max_reg) begin
        wait_max_reg <= wait_next;
      end
    end
  end

  assign stat_gl_grants   = grants_reg;
  assign stat_gl_wait_max = wait_max_reg;
`else
  assign stat_gl_grants   = '0;
  assign stat_gl_wait_max = '0;
`endif

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Self-checking bench for bg_rom_arbiter: vector table plus hand sequences, with a
// scoreboard matching each display/game-logic read return against its grant.
module tb_bg_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de;
  logic [9:0]  hcount;
  logic [8:0]  vcount;
  logic [3:0]  disp_pixel;
  logic        disp_valid;
  logic        gl_req;
  logic [8:0]  gl_x;
  logic [7:0]  gl_y;
  logic        gl_ack;
  logic        gl_rvalid;
  logic [3:0]  gl_rdata;
  logic        gl_oob;
  logic [16:0] rom_addr;
  logic [3:0]  rom_data;
  logic [15:0] stat_gl_grants;
  logic [15:0] stat_gl_wait_max;

  always #5 clk = ~clk;

  bg_rom_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .de               (de),
    .hcount           (hcount),
    .vcount           (vcount),
    .disp_pixel       (disp_pixel),
    .disp_valid       (disp_valid),
    .gl_req           (gl_req),
    .gl_x             (gl_x),
    .gl_y             (gl_y),
    .gl_ack           (gl_ack),
    .gl_rvalid        (gl_rvalid),
    .gl_rdata         (gl_rdata),
    .gl_oob           (gl_oob),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .stat_gl_grants   (stat_gl_grants),
    .stat_gl_wait_max (stat_gl_wait_max)
  );

  // ROM content is a fixed hash of the address so every location is predictable.
  function automatic logic [3:0] rom_fn(input logic [16:0] a);
    return a[3:0] ^ a[8:5] ^ a[16:13];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    bit         is_gl;
    bit         oob;
    logic [3:0] pix;
  } exp_t;

  typedef struct {
    bit de;
    int hc;
    int vc;
    bit req;
    int x;
    int y;
    bit ack;
    int addr;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every returned read must match the oldest outstanding grant.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (disp_valid || gl_rvalid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {30'd0, disp_valid, gl_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_gl) begin
          $display("txn gl   rdata=%0d oob=%0d (exp %0d/%0d)", gl_rdata, gl_oob, e.pix, e.oob);
          chk("gl_rvalid", gl_rvalid, 1);
          chk("gl_disp_valid", disp_valid, 0);
          chk("gl_rdata", gl_rdata, e.pix);
          chk("gl_oob", gl_oob, e.oob);
        end else begin
          $display("txn disp pixel=%0d (exp %0d)", disp_pixel, e.pix);
          chk("disp_valid", disp_valid, 1);
          chk("disp_gl_rvalid", gl_rvalid, 0);
          chk("disp_pixel", disp_pixel, e.pix);
        end
      end
    end
  end

  task automatic drive(input bit d, input int hc, input int vc, input bit r, input int x, input int y);
    de     = d;
    hcount = 10'(hc);
    vcount = 9'(vc);
    gl_req = r;
    gl_x   = 9'(x);
    gl_y   = 8'(y);
  endtask

  // One clock with the current inputs; optionally records the expected read return.
  task automatic step(input string name, input bit exp_ack, input int exp_addr, input bit push_en);
    exp_t e;
    if (push_en && de) begin
      e.is_gl = 1'b0;
      e.oob   = 1'b0;
      e.pix   = rom_fn(17'(exp_addr));
      sb.push_back(e);
    end else if (push_en && gl_req) begin
      e.is_gl = 1'b1;
      e.oob   = (gl_x >= 9'd320) || (gl_y >= 8'd240);
      e.pix   = e.oob ? 4'd0 : rom_fn(17'(exp_addr));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({name, "_ack"}, gl_ack, exp_ack);
    chk({name, "_addr"}, rom_addr, exp_addr);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rom_addr"}, rom_addr, 0);
    chk({name, "_gl_ack"}, gl_ack, 0);
    chk({name, "_disp_valid"}, disp_valid, 0);
    chk({name, "_disp_pixel"}, disp_pixel, 0);
    chk({name, "_gl_rvalid"}, gl_rvalid, 0);
    chk({name, "_gl_rdata"}, gl_rdata, 0);
    chk({name, "_gl_oob"}, gl_oob, 0);
    chk({name, "_stat_grants"}, stat_gl_grants, 0);
    chk({name, "_stat_wait"}, stat_gl_wait_max, 0);
  endtask

  function automatic vec_t mk(input bit d, input int hc, input int vc, input bit r,
                              input int x, input int y, input bit a, input int ad);
    vec_t v;
    v.de = d; v.hc = hc; v.vc = vc; v.req = r;
    v.x = x; v.y = y; v.ack = a; v.addr = ad;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int hits;
    vecs[0]  = mk(1,   5,   7, 0,   0,   0, 0,   962);
    vecs[1]  = mk(0,   0,   0, 1,  10,  20, 1,  6410);
    vecs[2]  = mk(0,   0,   0, 1,   0,   0, 1,     0);
    vecs[3]  = mk(0,   0,   0, 1, 319, 239, 1, 76799);
    vecs[4]  = mk(0,   0,   0, 1, 320,   0, 1, 76799);
    vecs[5]  = mk(0,   0,   0, 1,   5, 240, 1, 76799);
    vecs[6]  = mk(0,   0,   0, 0,   0,   0, 0, 76799);
    vecs[7]  = mk(1,   0,   0, 1,   1,   1, 0,     0);
    vecs[8]  = mk(1, 639, 479, 0,   0,   0, 0, 76799);
    vecs[9]  = mk(0,   0,   0, 1, 511, 255, 1, 76799);
    vecs[10] = mk(0,   0,   0, 1, 100,  50, 1, 16100);
    vecs[11] = mk(1, 100,   3, 0,   0,   0, 0,   370);
    vecs[12] = mk(0,   0,   0, 0,   0,   0, 0,   370);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].de, vecs[i].hc, vecs[i].vc, vecs[i].req, vecs[i].x, vecs[i].y);
      step($sformatf("vec%0d", i), vecs[i].ack, vecs[i].addr, 1'b1);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step("drain1", 0, 370, 1'b1);

    // Display holds off a pending request; grant lands on the first blanking cycle.
    drive(1, 2, 2, 1, 10, 20);
    repeat (4) step("prio_hold", 0, 321, 1'b1);
    drive(0, 2, 2, 1, 10, 20);
    step("prio_grant", 1, 6410, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step("prio_drain", 0, 6410, 1'b1);

    // Request withdrawn before it could be granted.
    drive(1, 2, 2, 1, 30, 30);
    repeat (2) step("wd_hold", 0, 321, 1'b1);
    drive(0, 0, 0, 0, 30, 30);
    repeat (3) step("wd_idle", 0, 321, 1'b1);

    // Reset while a granted read is in flight: its return must never appear.
    drive(0, 0, 0, 1, 7, 3);
    step("rst_grant", 1, 967, 1'b0);
    gl_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (gl_rvalid || disp_valid) hits++;
    end
    chk("rst_no_rvalid", hits, 0);
    chk("rst_addr", rom_addr, 0);

    // Statistics: 100-cycle wait then a 5-cycle wait.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 1, 0);
    repeat (100) step("st_wait1", 0, 0, 1'b1);
    drive(0, 0, 0, 1, 1, 0);
    step("st_grant1", 1, 1, 1'b1);
    drive(0, 0, 0, 0, 1, 0);
    step("st_gap", 0, 1, 1'b1);
    drive(1, 0, 0, 1, 2, 0);
    repeat (5) step("st_wait2", 0, 0, 1'b1);
    drive(0, 0, 0, 1, 2, 0);
    step("st_grant2", 1, 2, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step("st_drain", 0, 2, 1'b1);
`ifdef BG_ARB_STATS_EN
    chk("stat_gl_grants", stat_gl_grants, 2);
    chk("stat_gl_wait_max", stat_gl_wait_max, 100);
`else
    chk("stat_gl_grants", stat_gl_grants, 0);
    chk("stat_gl_wait_max", stat_gl_wait_max, 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
